// File: rtl/dmem_responder.sv
// Data-memory responder for the 64-bit pipeline memory stage.
// Little-endian, byte-addressed RAM behind valid/ready request and response
// channels, with programmable wait states, byte-lane store merging,
// sign/zero-extending loads and error responses for bad accesses.
module dmem_responder #(
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH_BYTES);

  // ACCESS is the single cycle in which the captured request touches the RAM;
  // both the zero-wait path and the error path pass through it so that the
  // response always appears one edge after the access edge.
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          write_q;
  logic [2:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic          err_q;
  logic [63:0]   rdata_q;
  logic          rspErr_q;

  logic [7:0]    mem [DEPTH_BYTES];

  logic          accept;
  logic [3:0]    reqSizeBytes;
  logic [64:0]   reqEnd;
  logic          reqMisaligned;
  logic          reqErr;
  logic [63:0]   rawData;
  logic [63:0]   loadData;
  logic [7:0]    wrMask;

  assign accept    = req_valid && (state_q == S_IDLE);
  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rspErr_q;

  // Decode the fault condition from the live request so it can be captured
  // alongside the request; the end address uses 65 bits so a wrap past 2^64
  // is still seen as out of range.
  always_comb begin
    reqSizeBytes  = 4'd1 << req_size[1:0];
    reqEnd        = {1'b0, req_addr} + {61'b0, reqSizeBytes};
    reqMisaligned = 1'b0;
    case (req_size[1:0])
      2'b01:   reqMisaligned = req_addr[0];
      2'b10:   reqMisaligned = |req_addr[1:0];
      2'b11:   reqMisaligned = |req_addr[2:0];
      default: reqMisaligned = 1'b0;
    endcase
    reqErr = reqMisaligned
          || (reqEnd > 65'(DEPTH_BYTES))
          || (req_size == 3'b111)
          || (req_write && req_size[2]);
  end

  // Gather eight bytes little-endian from the captured address and apply the
  // load extension; bytes beyond the access size are simply ignored.
  always_comb begin
    rawData = '0;
    for (int i = 0; i < 8; i++) begin
      rawData[8*i +: 8] = mem[addr_q + AW'(i)];
    end
    case (size_q)
      3'b000:  loadData = {{56{rawData[7]}},  rawData[7:0]};
      3'b001:  loadData = {{48{rawData[15]}}, rawData[15:0]};
      3'b010:  loadData = {{32{rawData[31]}}, rawData[31:0]};
      3'b100:  loadData = {56'b0, rawData[7:0]};
      3'b101:  loadData = {48'b0, rawData[15:0]};
      3'b110:  loadData = {32'b0, rawData[31:0]};
      default: loadData = rawData;
    endcase
  end

  // Byte enables for a store of the captured size.
  always_comb begin
    case (size_q[1:0])
      2'b00:   wrMask = 8'h01;
      2'b01:   wrMask = 8'h03;
      2'b10:   wrMask = 8'h0F;
      default: wrMask = 8'hFF;
    endcase
  end

  // Next-state logic for the IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE walk.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (reqErr || (WAIT_CYCLES == 0)) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: state_d = S_RESP;
      default: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
    endcase
  end

  // Control, request capture and response registers; reset drops anything
  // in flight but leaves the RAM alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rspErr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        addr_q  <= req_addr[AW-1:0];
        wdata_q <= req_wdata;
        err_q   <= reqErr;
      end
      if (state_q == S_ACCESS) begin
        rdata_q  <= (write_q || err_q) ? 64'b0 : loadData;
        rspErr_q <= err_q;
      end
    end
  end

  // Store commit: only the enabled low bytes of the captured data land in
  // the RAM, and a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (rst && (state_q == S_ACCESS) && write_q && !err_q) begin
      for (int i = 0; i < 8; i++) begin
        if (wrMask[i]) begin
          mem[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule
